// File: rtl/sift_pkg.sv
// Shared types for the DoG scan controller.
//   PIX_W / COORD_W / WIN : pixel width, coordinate width, window height (rows per read)
//   scan_tag_t            : read tag {x, y, dir} carried alongside an outstanding read
//   dog_beat_t            : one window beat {x, y, dir, data[WIN]} with data[0] = top row
//   scan_state_t          : controller FSM states
package sift_pkg;

  localparam int unsigned PIX_W   = 8;
  localparam int unsigned COORD_W = 8;
  localparam int unsigned WIN     = 5;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               dir;
  } scan_tag_t;

  typedef struct packed {
    logic [COORD_W-1:0]          x;
    logic [COORD_W-1:0]          y;
    logic                        dir;
    logic [WIN-1:0][PIX_W-1:0]   data;
  } dog_beat_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scan_state_t;

endpackage

// File: rtl/dog_scan_ctrl_if.sv
// Bus bundle of the DoG scan controller.
//   control : start (in), busy/done (out)
//   memory  : mem_rd, mem_x, mem_y (out), mem_data (in, 5 rows packed, [7:0] = top row)
//   DoGUnit : dog_stall (in), dog_valid, dog_x, dog_y, dog_dir, dog_data1..5 (out)
// master = controller side, slave = environment side.
interface dog_scan_ctrl_if;
  import sift_pkg::*;

  logic                     start;
  logic                     busy;
  logic                     done;
  logic                     mem_rd;
  logic [COORD_W-1:0]       mem_x;
  logic [COORD_W-1:0]       mem_y;
  logic [WIN*PIX_W-1:0]     mem_data;
  logic                     dog_stall;
  logic                     dog_valid;
  logic [COORD_W-1:0]       dog_x;
  logic [COORD_W-1:0]       dog_y;
  logic                     dog_dir;
  logic [PIX_W-1:0]         dog_data1;
  logic [PIX_W-1:0]         dog_data2;
  logic [PIX_W-1:0]         dog_data3;
  logic [PIX_W-1:0]         dog_data4;
  logic [PIX_W-1:0]         dog_data5;

  modport master (
    input  start, mem_data, dog_stall,
    output busy, done, mem_rd, mem_x, mem_y,
           dog_valid, dog_x, dog_y, dog_dir,
           dog_data1, dog_data2, dog_data3, dog_data4, dog_data5
  );

  modport slave (
    output start, mem_data, dog_stall,
    input  busy, done, mem_rd, mem_x, mem_y,
           dog_valid, dog_x, dog_y, dog_dir,
           dog_data1, dog_data2, dog_data3, dog_data4, dog_data5
  );

endinterface

// File: rtl/dog_ret_fifo.sv
// Return buffer for frame-memory reads: synchronous FIFO of dog_beat_t.
//   clk, rst     : clock, asynchronous active-high reset
//   push, din    : write one beat
//   pop, dout    : dout shows the head entry; pop advances past it
//   full, empty  : occupancy flags
//   count        : number of stored entries
// Push and pop in the same cycle are allowed, including when full.
module dog_ret_fifo
  import sift_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  dog_beat_t        din,
  input  logic             pop,
  output dog_beat_t        dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  dog_beat_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) wr_d = ptr_inc(wr_q);
    if (pop)  rd_d = ptr_inc(rd_q);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout  = mem_q[rd_q];
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/dog_scan_ctrl.sv
// Serpentine frame scanner feeding one DoGUnit.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : dog_scan_ctrl_if.master
//              start/busy/done     frame control
//              mem_rd/mem_x/mem_y  column reads, 5 rows starting at band mem_y
//              mem_data            read return, MEM_LAT cycles after mem_rd
//              dog_stall/dog_*     registered, stallable output to the DoGUnit
// Reads are credit-limited so that every outstanding read has a FIFO slot.
module dog_scan_ctrl
  import sift_pkg::*;
#(
  parameter int unsigned IMG_W      = 64,
  parameter int unsigned IMG_H      = 48,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             rst,
  dog_scan_ctrl_if.master bus
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_H - 5);

  scan_state_t               state_q, state_d;
  logic [COORD_W-1:0]        x_q, x_d;
  logic [COORD_W-1:0]        y_q, y_d;
  logic                      dir_q, dir_d;
  logic [MEM_LAT-1:0]        vld_q, vld_d;
  scan_tag_t [MEM_LAT-1:0]   tag_q, tag_d;
  dog_beat_t                 beat_q, beat_d;
  logic                      valid_q, valid_d;

  logic                      rd;
  logic                      row_end;
  logic                      last_rd;
  int unsigned               inflight;
  logic                      pop;
  logic                      fifo_push;
  dog_beat_t                 fifo_din;
  dog_beat_t                 fifo_dout;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [CNT_W-1:0]          fifo_count;

  dog_ret_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Scan FSM and x/y/dir counters.
  always_comb begin
    inflight = $countones(vld_q);
    row_end  = dir_q ? (x_q == '0) : (x_q == X_LAST);
    last_rd  = row_end && (y_q == Y_LAST);
    // Credits cover both buffered beats and reads still in the memory pipe.
    rd       = (state_q == SCAN) && ((32'(fifo_count) + inflight) < FIFO_DEPTH);

    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SCAN;
          x_d     = '0;
          y_d     = '0;
          dir_d   = 1'b0;
        end
      end
      SCAN: begin
        if (rd) begin
          if (last_rd) begin
            state_d = DRAIN;
          end else if (row_end) begin
            // Next band starts at the column just read, heading back.
            y_d   = y_q + 1'b1;
            dir_d = ~dir_q;
          end else begin
            x_d = dir_q ? x_q - 1'b1 : x_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (fifo_empty && (inflight == 0)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Tag pipe mirrors the memory latency; the last stage marks a returning beat.
  always_comb begin
    vld_d    = vld_q;
    tag_d    = tag_q;
    vld_d[0] = rd;
    tag_d[0] = '{x: x_q, y: y_q, dir: dir_q};
    for (int unsigned i = 1; i < MEM_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
  end

  // Return capture and registered output stage.
  always_comb begin
    pop           = !fifo_empty && (!valid_q || !bus.dog_stall);
    fifo_push     = vld_q[MEM_LAT-1] && (!fifo_full || pop);
    fifo_din.x    = tag_q[MEM_LAT-1].x;
    fifo_din.y    = tag_q[MEM_LAT-1].y;
    fifo_din.dir  = tag_q[MEM_LAT-1].dir;
    fifo_din.data = bus.mem_data;

    beat_d  = beat_q;
    valid_d = valid_q;
    if (pop) begin
      beat_d  = fifo_dout;
      valid_d = 1'b1;
    end else if (valid_q && !bus.dog_stall) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      dir_q   <= 1'b0;
      vld_q   <= '0;
      tag_q   <= '0;
      beat_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      vld_q   <= vld_d;
      tag_q   <= tag_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.mem_rd    = rd;
  assign bus.mem_x     = x_q;
  assign bus.mem_y     = y_q;
  assign bus.dog_valid = valid_q;
  assign bus.dog_x     = beat_q.x;
  assign bus.dog_y     = beat_q.y;
  assign bus.dog_dir   = beat_q.dir;
  assign bus.dog_data1 = beat_q.data[0];
  assign bus.dog_data2 = beat_q.data[1];
  assign bus.dog_data3 = beat_q.data[2];
  assign bus.dog_data4 = beat_q.data[3];
  assign bus.dog_data5 = beat_q.data[4];

endmodule

// File: tb/tb_dog_scan_ctrl.sv
// Bench for dog_scan_ctrl on an 8x6 frame with a 2-cycle behavioural memory.
module tb_dog_scan_ctrl;

  localparam int unsigned IMG_W      = 8;
  localparam int unsigned IMG_H      = 6;
  localparam int unsigned MEM_LAT    = 2;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned NBEATS     = IMG_W * (IMG_H - 4);
  localparam int unsigned BUDGET     = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dog_scan_ctrl_if bus ();

  dog_scan_ctrl #(
    .IMG_W      (IMG_W),
    .IMG_H      (IMG_H),
    .MEM_LAT    (MEM_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural frame memory: pixel(x,r) = (x + r*16) & 8'hFF.
  function automatic logic [7:0] pix(input int unsigned x, input int unsigned r);
    return 8'((x + r * 16) & 32'hFF);
  endfunction

  function automatic logic [39:0] column(input int unsigned x, input int unsigned y);
    logic [39:0] c;
    for (int unsigned k = 0; k < 5; k++) c[k*8 +: 8] = pix(x, y + k);
    return c;
  endfunction

  logic [39:0] mpipe [MEM_LAT];
  always @(posedge clk) begin
    mpipe[0] <= bus.mem_rd ? column(32'(bus.mem_x), 32'(bus.mem_y)) : 40'h0;
    for (int unsigned i = 1; i < MEM_LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign bus.mem_data = mpipe[MEM_LAT-1];

  // Scoreboard and bookkeeping.
  logic [56:0] sb [$];
  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc = 0, start_cyc = 0, accepted = 0, done_cnt = 0;
  int unsigned last_acc_cyc = 0, done_cyc = 0, first_valid_cyc = 0;
  logic        got_first = 1'b0;
  logic        done_busy = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [56:0] exp_beat(input int unsigned x, input int unsigned y);
    return {8'(x), 8'(y), 1'(y % 2), column(x, y)};
  endfunction

  function automatic logic [56:0] obs_beat();
    return {bus.dog_x, bus.dog_y, bus.dog_dir, bus.dog_data5, bus.dog_data4,
            bus.dog_data3, bus.dog_data2, bus.dog_data1};
  endfunction

  function automatic logic [76:0] all_outputs();
    return {bus.busy, bus.done, bus.mem_rd, bus.mem_x, bus.mem_y, obs_beat(), bus.dog_valid};
  endfunction

  task automatic push_frame();
    for (int unsigned y = 0; y < IMG_H - 4; y++)
      for (int unsigned i = 0; i < IMG_W; i++)
        sb.push_back(exp_beat((y % 2 == 0) ? i : IMG_W - 1 - i, y));
  endtask

  // Drive inputs for the coming edge, observe registered outputs, advance one cycle.
  task automatic step(input logic s, input logic st);
    logic [56:0] exp;
    bus.dog_stall = s;
    bus.start     = st;
    if (bus.dog_valid && !got_first) begin
      got_first       = 1'b1;
      first_valid_cyc = cyc;
    end
    if (bus.dog_valid && !s) begin
      exp = (sb.size() != 0) ? sb.pop_front() : '1;
      check($sformatf("beat%0d", accepted), 128'(obs_beat()), 128'(exp));
      if (accepted == 12) begin
        check("x3y1_data1", 128'(bus.dog_data1), 128'(8'h13));
        check("x3y1_data5", 128'(bus.dog_data5), 128'(8'h53));
      end
      accepted++;
      last_acc_cyc = cyc;
    end
    if (bus.done) begin
      done_cnt++;
      done_cyc  = cyc;
      done_busy = bus.busy;
    end
    @(negedge clk);
    cyc++;
  endtask

  // mode 0: no stall, 1: 10-cycle stall at beat 3, 2: alternating stall, 3: start pulse at beat 5
  task automatic run_frame(input int unsigned mode, input logic tail);
    int unsigned budget;
    int unsigned stall_left;
    logic        alt, stalled_once, pulsed, s, st;
    logic [56:0] held;
    accepted     = 0;
    done_cnt     = 0;
    got_first    = 1'b0;
    alt          = 1'b1;
    stall_left   = 0;
    stalled_once = 1'b0;
    pulsed       = 1'b0;
    held         = '0;
    check("busy_before_start", 128'(bus.busy), 128'(0));
    push_frame();
    start_cyc = cyc;
    step(1'b0, 1'b1);
    check("busy_after_start", 128'(bus.busy), 128'(1));
    budget = 0;
    while (!(done_cnt != 0 && accepted >= NBEATS) && budget < BUDGET) begin
      s  = 1'b0;
      st = 1'b0;
      case (mode)
        1: begin
          if (!stalled_once && bus.dog_valid && accepted == 3) begin
            stalled_once = 1'b1;
            stall_left   = 10;
            held         = sb[0];
          end
          if (stall_left != 0) begin
            s = 1'b1;
            check("stall_hold", 128'(obs_beat()), 128'(held));
            if (stall_left == 1) check("stall_mem_rd", 128'(bus.mem_rd), 128'(0));
            stall_left--;
          end
        end
        2: begin
          s   = alt;
          alt = ~alt;
        end
        3: begin
          if (!pulsed && accepted == 5) begin
            pulsed = 1'b1;
            st     = 1'b1;
            check("busy_at_pulse", 128'(bus.busy), 128'(1));
          end
        end
        default: ;
      endcase
      step(s, st);
      budget++;
    end
    check("frame_in_budget", 128'(budget < BUDGET), 128'(1));
    check("busy_in_done", 128'(done_busy), 128'(1));
    if (mode == 0) begin
      // start is driven in step start_cyc; first valid follows the edge MEM_LAT+2 edges later
      check("first_latency", 128'(first_valid_cyc - start_cyc), 128'(MEM_LAT + 3));
      check("done_after_last", 128'(done_cyc - last_acc_cyc), 128'(1));
    end
    if (tail) begin
      for (int unsigned i = 0; i < 10; i++) step(1'b0, 1'b0);
      check("busy_idle", 128'(bus.busy), 128'(0));
    end
    check("beat_count", 128'(accepted), 128'(NBEATS));
    check("done_pulses", 128'(done_cnt), 128'(1));
    check("sb_empty", 128'(sb.size()), 128'(0));
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.dog_stall = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 128'(all_outputs()), 128'(0));
    rst = 1'b0;
    step(1'b0, 1'b0);
    check("idle_outputs", 128'(all_outputs()), 128'(0));

    // Basic scan
    run_frame(0, 1'b1);
    // Long stall at beat 3
    run_frame(1, 1'b1);
    // Alternating stall
    run_frame(2, 1'b1);
    // start pulsed mid-frame
    run_frame(3, 1'b1);

    // Reset mid-frame
    accepted  = 0;
    got_first = 1'b0;
    push_frame();
    step(1'b0, 1'b1);
    for (int unsigned i = 0; i < 8; i++) step(1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("midreset_outputs", 128'(all_outputs()), 128'(0));
    @(negedge clk);
    check("midreset_held", 128'(all_outputs()), 128'(0));
    rst = 1'b0;
    sb.delete();
    for (int unsigned i = 0; i < 4; i++) begin
      check("post_reset_quiet", 128'({bus.dog_valid, bus.busy}), 128'(0));
      step(1'b0, 1'b0);
    end
    run_frame(0, 1'b1);

    // Back-to-back frames: second start lands in the idle cycle after done
    run_frame(0, 1'b0);
    run_frame(0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
